// File: rtl/rca_seq_ctrl_if.sv
// rca_seq_ctrl_if: operand/result handshake bundle for rca_seq_ctrl.
// master = operand source / result consumer, slave = the controller.
// op_sub exists only when RCA_SUB_EN is defined.
interface rca_seq_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_cin;
`ifdef RCA_SUB_EN
   logic             op_sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             result_cout;
   logic             overflow;

`ifdef RCA_SUB_EN
   modport master (output in_valid, op_a, op_b, op_cin, op_sub, out_ready,
                   input  in_ready, out_valid, result, result_cout, overflow);
   modport slave  (input  in_valid, op_a, op_b, op_cin, op_sub, out_ready,
                   output in_ready, out_valid, result, result_cout, overflow);
`else
   modport master (output in_valid, op_a, op_b, op_cin, out_ready,
                   input  in_ready, out_valid, result, result_cout, overflow);
   modport slave  (input  in_valid, op_a, op_b, op_cin, out_ready,
                   output in_ready, out_valid, result, result_cout, overflow);
`endif
endinterface

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: WIDTH-bit add (optionally subtract) performed one nibble per
// cycle on an external shared 4-bit ripple-carry adder (rca_* ports).
// Optional feature macro: RCA_SUB_EN (adds op_sub, computes A + ~B + 1).
// Latency is N+1 cycles from acceptance to out_valid, N = WIDTH/4.
module rca_seq_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   rca_seq_ctrl_if.slave bus,
   output logic [3:0]    rca_a,
   output logic [3:0]    rca_b,
   output logic          rca_cin,
   input  logic [3:0]    rca_sum,
   input  logic          rca_cout
);
   localparam int N  = WIDTH / 4;
   localparam int SW = (N > 1) ? $clog2(N) : 1;
   localparam logic [SW-1:0] LAST = SW'(N - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]          state;
   logic [SW-1:0]       step;
   logic [N-1:0][3:0]   a_reg;
   logic [N-1:0][3:0]   b_reg;
   logic [N-1:0][3:0]   res_reg;
   logic                carry_reg;
   logic                cout_reg;
   logic                ovf_reg;
   logic                sub_reg;
   logic                sub_in;
   logic                accept;

   assign accept = (state == IDLE) && bus.in_valid;

`ifdef RCA_SUB_EN
   assign sub_in = bus.op_sub;

   // Subtract flag travels with the operands for the whole operation.
   always_ff @(posedge clk) begin
      if (!rst_n)
         sub_reg <= 1'b0;
      else if (accept)
         sub_reg <= bus.op_sub;
   end
`else
   assign sub_in  = 1'b0;
   assign sub_reg = 1'b0;
`endif

   // Drive the shared adder only while stepping; quiet zeros otherwise.
   always_comb begin
      rca_a   = 4'h0;
      rca_b   = 4'h0;
      rca_cin = 1'b0;
      if (state == RUN) begin
         rca_a   = a_reg[step];
         rca_b   = sub_reg ? ~b_reg[step] : b_reg[step];
         rca_cin = carry_reg;
      end
   end

   // Main sequencer: accept operands, walk the nibbles, hold the result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         step      <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_reg     <= bus.op_a;
                  b_reg     <= bus.op_b;
                  // Subtraction forces the +1 of two's-complement negate.
                  carry_reg <= sub_in ? 1'b1 : bus.op_cin;
                  step      <= '0;
                  state     <= RUN;
               end
            end
            RUN: begin
               res_reg[step] <= rca_sum;
               carry_reg     <= rca_cout;
               step          <= step + SW'(1);
               if (step == LAST) begin
                  cout_reg <= rca_cout;
                  // a^b^sum on the MSB recovers the carry into it.
                  ovf_reg  <= rca_a[3] ^ rca_b[3] ^ rca_sum[3] ^ rca_cout;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready    = rst_n && (state == IDLE);
   assign bus.out_valid   = (state == DONE);
   assign bus.result      = res_reg;
   assign bus.result_cout = cout_reg;
   assign bus.overflow    = ovf_reg;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb_rca_seq_ctrl: scoreboard bench for rca_seq_ctrl (WIDTH=16).
// Subtraction cases are compiled in when RCA_SUB_EN is defined.
module tb_rca_seq_ctrl;
   localparam int W = 16;
   localparam int N = W / 4;

   typedef struct packed {
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] rca_a, rca_b, rca_sum;
   logic       rca_cin, rca_cout;

   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sbq[$];

   rca_seq_ctrl_if #(.WIDTH(W)) bus ();

   rca_seq_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .rca_a    (rca_a),
      .rca_b    (rca_b),
      .rca_cin  (rca_cin),
      .rca_sum  (rca_sum),
      .rca_cout (rca_cout)
   );

   // External 4-bit adder, purely combinational.
   assign {rca_cout, rca_sum} = {1'b0, rca_a} + {1'b0, rca_b} + {4'b0, rca_cin};

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: whole-word arithmetic, signed range test for overflow.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      exp_t         e;
      logic [W-1:0] bb;
      int           c, s, ss;
      bb = sub ? ~b : b;
      c  = sub ? 1 : int'(cin);
      s  = int'(a) + int'(bb) + c;
      ss = int'($signed(a)) + int'($signed(bb)) + c;
      e.res  = s[W-1:0];
      e.cout = s[W];
      e.ovf  = (ss > 32767) || (ss < -32768);
      return e;
   endfunction

   // Carry entering nibble k = carry out of the low 4k bits.
   function automatic logic carry_in(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin, input logic sub, input int k);
      logic [W-1:0] bb;
      int           c, mask;
      bb   = sub ? ~b : b;
      c    = sub ? 1 : int'(cin);
      mask = (1 << (4 * k)) - 1;
      return 1'(((int'(a) & mask) + (int'(bb) & mask) + c) >> (4 * k));
   endfunction

   // Monitor: pops on each new result, then checks it stays put while held.
   logic prev_v = 1'b0;
   exp_t cur;
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.out_valid) begin
         if (!prev_v) begin
            if (sbq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_result: got %0h with empty scoreboard", bus.result);
            end else begin
               e = sbq.pop_front();
               chk("result", bus.result, e.res);
               chk("result_cout", bus.result_cout, e.cout);
               chk("overflow", bus.overflow, e.ovf);
               cur <= e;
            end
         end else begin
            chk("hold_result", bus.result, cur.res);
            chk("hold_cout", bus.result_cout, cur.cout);
            chk("hold_ovf", bus.overflow, cur.ovf);
         end
         chk("in_ready_done", bus.in_ready, 0);
      end
      prev_v <= rst_n && bus.out_valid;
   end

   task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub);
      bus.op_a   = a;
      bus.op_b   = b;
      bus.op_cin = cin;
`ifdef RCA_SUB_EN
      bus.op_sub = sub;
`endif
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input int hold);
      logic [W-1:0] bb;
      bb = sub ? ~b : b;
      @(posedge clk); #1;
      drive_ops(a, b, cin, sub);
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("in_ready_idle", bus.in_ready, 1);
      @(posedge clk);
      sbq.push_back(model(a, b, cin, sub));
      #1;
      bus.in_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         chk("rca_cin", rca_cin, carry_in(a, b, cin, sub, k));
         chk("rca_a", rca_a, a[k*4 +: 4]);
         chk("rca_b", rca_b, bb[k*4 +: 4]);
         chk("out_valid_run", bus.out_valid, 0);
      end
      @(negedge clk);
      chk("latency_out_valid", bus.out_valid, 1);
      if (hold > 0) begin
         #1;
         drive_ops(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
         bus.in_valid = 1'b1;
         repeat (hold) @(negedge clk);
         chk("held_out_valid", bus.out_valid, 1);
      end
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("idle_out_valid", bus.out_valid, 0);
      chk("idle_in_ready", bus.in_ready, 1);
   endtask

   task automatic reset_mid_op();
      logic [W-1:0] a;
      a = 16'h0ABC;
      @(posedge clk); #1;
      drive_ops(a, 16'h0DEF, 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      @(posedge clk);
      sbq.push_back(model(a, 16'h0DEF, 1'b0, 1'b0));
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("step2_rca_a", rca_a, a[11:8]);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      void'(sbq.pop_back());
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_rca_a", rca_a, 0);
      chk("rst_rca_b", rca_b, 0);
      chk("rst_rca_cin", rca_cin, 0);
      chk("rst_in_ready", bus.in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic s;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      drive_ops('0, '0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", bus.in_ready, 0);
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_result", bus.result, 0);
      chk("reset_cout", bus.result_cout, 0);
      chk("reset_ovf", bus.overflow, 0);
      chk("reset_rca_a", rca_a, 0);
      chk("reset_rca_b", rca_b, 0);
      chk("reset_rca_cin", rca_cin, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
`ifdef RCA_SUB_EN
      do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
      do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0);
      do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1);
`endif
      do_op(16'h1357, 16'h2468, 1'b1, 1'b0, 3);
      reset_mid_op();
      do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);
      do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 0);

      for (int i = 0; i < 20; i++) begin
`ifdef RCA_SUB_EN
         s = 1'($urandom);
`else
         s = 1'b0;
`endif
         do_op(W'($urandom), W'($urandom), 1'($urandom), s, int'($urandom_range(0, 3)));
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/rca_seq_ctrl.md
# rca_seq_ctrl

Sequencing controller that performs WIDTH-bit additions on a single shared 4-bit ripple-carry adder, one nibble per cycle. Carry is chained between nibbles through a registered carry flop. Operands enter through a valid/ready input handshake; results leave through a valid/ready output handshake. The block sits between an operand source and a result consumer and instantiates nothing itself: the 4-bit adder is external and connects through the rca_* ports.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8; N = WIDTH/4 nibble steps
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  controller can accept operands
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- op_cin  input  1  carry-in of the full-width addition
- op_sub  input  1  subtract request; present only with RCA_SUB_EN
- rca_a  output  4  adder A nibble
- rca_b  output  4  adder B nibble
- rca_cin  output  1  adder carry-in
- rca_sum  input  4  adder sum, combinational from rca_a/rca_b/rca_cin
- rca_cout  input  1  adder carry-out
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum
- result_cout  output  1  final carry-out
- overflow  output  1  two's-complement signed overflow

## Operation
- FSM states IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch op_a to a_reg and op_b to b_reg.
  - Set carry_reg to op_cin (to 1 when op_sub=1).
  - Clear step to 0. Go to RUN.
- RUN:
  - rca_a = a_reg[4*step+3 : 4*step].
  - rca_b = same nibble of b_reg, bitwise inverted when the latched sub flag is set.
  - rca_cin = carry_reg.
  - Each clock: write rca_sum into result nibble `step`, set carry_reg to rca_cout, increment step.
  - On step = N-1: also capture result_cout = rca_cout and overflow = (rca_a[3] ^ rca_b[3] ^ rca_sum[3]) ^ rca_cout, then go to DONE.
- DONE:
  - out_valid=1. result, result_cout and overflow are held stable.
  - On out_ready: go to IDLE.
- Outside RUN, rca_a/rca_b/rca_cin are driven 0.
- in_ready=0 in RUN and DONE. There is no operand queuing; in_valid is ignored outside IDLE.
- result is updated in place during RUN. result is meaningful only while out_valid=1.
- Reset values: in_ready=0 during reset, then 1 in IDLE. out_valid=0, result=0, result_cout=0, overflow=0, rca_a=0, rca_b=0, rca_cin=0.
- Reset asserted in any state returns the FSM to IDLE at the next edge and abandons the operation in progress. No partial result is presented.

## Timing
- The acceptance edge is E0, where in_valid && in_ready.
- The RUN state occupies the cycles between edges E0 and E_N.
- out_valid rises after E_N, so latency is N+1 cycles from acceptance to out_valid.
- The earliest next acceptance is the cycle after the out_valid && out_ready edge. Minimum initiation interval is N+2 cycles.
- The adder path is combinational inside one cycle: rca_* out → rca_sum/rca_cout in → register.

## Configuration
- RCA_SUB_EN defined:
  - The op_sub port exists and is latched with the operands.
  - Subtraction computes A + ~B + 1; op_cin is ignored when op_sub=1.
  - result_cout=1 means no borrow.
- RCA_SUB_EN undefined:
  - The op_sub port is absent and the internal sub flag is tied to 0.
  - Addition only.

## Test plan
- WIDTH=16. Inputs 0x00FF + 0x0001, cin=0 → after 4 RUN cycles: result=0x0100, result_cout=0, overflow=0. out_valid rises 5 cycles after acceptance.
- Inputs 0xFFFF + 0x0001 → result=0x0000, result_cout=1, overflow=0. Inputs 0x7FFF + 0x0001 → result=0x8000, result_cout=0, overflow=1.
- RCA_SUB_EN defined, op_sub=1. Inputs 0x0005 − 0x0007 → result=0xFFFE, result_cout=0. Inputs 0x0007 − 0x0005 → result=0x0002, result_cout=1.
- Hold out_ready=0 for 3 cycles in DONE → result/out_valid stay stable, in_ready=0, and a new in_valid is not accepted. Release out_ready → IDLE, then accept the next operands.
- Assert rst_n=0 for one cycle when step=2 → next cycle: IDLE, out_valid=0, result=0, rca_* = 0. A fresh 0x1234 + 0x1111 then yields 0x2345.
- Per-cycle check of rca_cin against the expected nibble carries during 0x0F0F + 0x0101 → rca_cin sequence 0,1,0,1 with result=0x1010.
